// File: rtl/ras_ckpt_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ras_ckpt_q : RAS checkpoint FIFO; snapshots pointer/top per branch,        |
// |              retires in order, emits a one-cycle restore on a mispredict.  |
// | Option macro: RAS_CKPT_TOP_EN (store and restore the top-of-stack value).  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ras_ckpt_q #(
  parameter int XLEN  = 32,
  parameter int PTR_W = 3,
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic [PTR_W-1:0]         alloc_ptr,
  input  logic [XLEN-1:0]          alloc_top,
  output logic [TAG_W-1:0]         alloc_tag,
  input  logic                     resolve_valid,
  input  logic [TAG_W-1:0]         resolve_tag,
  input  logic                     resolve_mispredict,
  output logic                     restore_valid,
  output logic [PTR_W-1:0]         restore_ptr,
  output logic [XLEN-1:0]          restore_top,
  output logic                     tag_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] c_DEPTH_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] ptr_mem_q [DEPTH];
  logic [TAG_W-1:0] tag_mem_q [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
  logic             tag_err_q, tag_err_d;
  logic             restore_valid_q;
  logic [PTR_W-1:0] restore_ptr_q;

  logic w_mispredict, w_head_hit, w_accept, w_pop, w_restore, w_empty;

  always_comb begin
    w_mispredict = resolve_valid && resolve_mispredict;
    w_head_hit   = (count_q != '0) && (tag_mem_q[head_q] == resolve_tag);
    // A same-cycle correct resolve does not free a slot for this cycle's alloc.
    alloc_ready  = (count_q < c_DEPTH_CNT) && !flush && !w_mispredict;
    w_accept     = alloc_valid && alloc_ready;
    w_pop        = !flush && resolve_valid && !resolve_mispredict && w_head_hit;
    w_restore    = !flush && w_mispredict && w_head_hit;
    w_empty      = flush || w_mispredict;

    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    tag_cnt_d = tag_cnt_q;
    tag_err_d = tag_err_q | (!flush && resolve_valid && !w_head_hit);

    if (w_empty) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_accept) tail_d = tail_q + IDX_W'(1);
      if (w_pop)    head_d = head_q + IDX_W'(1);
      count_d = count_q + CNT_W'(w_accept) - CNT_W'(w_pop);
    end

    // Tag counter is never rewound by a mispredict or flush.
    if (w_accept) tag_cnt_d = tag_cnt_q + TAG_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      tag_cnt_q       <= '0;
      tag_err_q       <= 1'b0;
      restore_valid_q <= 1'b0;
      restore_ptr_q   <= '0;
    end else begin
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      tag_cnt_q       <= tag_cnt_d;
      tag_err_q       <= tag_err_d;
      restore_valid_q <= w_restore;
      if (w_restore) restore_ptr_q <= ptr_mem_q[head_q];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      ptr_mem_q[tail_q] <= alloc_ptr;
      tag_mem_q[tail_q] <= tag_cnt_q;
    end
  end

`ifdef RAS_CKPT_TOP_EN
  logic [XLEN-1:0] top_mem_q [DEPTH];
  logic [XLEN-1:0] restore_top_q;

  always_ff @(posedge clk) begin
    if (w_accept) top_mem_q[tail_q] <= alloc_top;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)          restore_top_q <= '0;
    else if (w_restore) restore_top_q <= top_mem_q[head_q];
  end

  assign restore_top = restore_top_q;
`else
  logic w_unused_top;
  assign w_unused_top = ^alloc_top;
  assign restore_top  = '0;
`endif

  assign alloc_tag     = tag_cnt_q;
  assign restore_valid = restore_valid_q;
  assign restore_ptr   = restore_ptr_q;
  assign tag_err       = tag_err_q;
  assign count         = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ras_ckpt_q.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ras_ckpt_q : directed + randomized bench with a queue-based model.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_ras_ckpt_q;

  localparam int XLEN  = 32;
  localparam int PTR_W = 3;
  localparam int DEPTH = 4;
  localparam int TAG_W = 3;
`ifdef RAS_CKPT_TOP_EN
  localparam bit TOP_EN = 1'b1;
`else
  localparam bit TOP_EN = 1'b0;
`endif

  logic             clk, reset, flush, alloc_valid, alloc_ready;
  logic [PTR_W-1:0] alloc_ptr;
  logic [XLEN-1:0]  alloc_top;
  logic [TAG_W-1:0] alloc_tag, resolve_tag;
  logic             resolve_valid, resolve_mispredict, restore_valid, tag_err;
  logic [PTR_W-1:0] restore_ptr;
  logic [XLEN-1:0]  restore_top;
  logic [2:0]       count;

  ras_ckpt_q #(.XLEN(XLEN), .PTR_W(PTR_W), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_ptr(alloc_ptr), .alloc_top(alloc_top), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict),
    .restore_valid(restore_valid), .restore_ptr(restore_ptr),
    .restore_top(restore_top), .tag_err(tag_err), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [PTR_W-1:0] ptr;
    logic [XLEN-1:0]  top;
    logic [TAG_W-1:0] tag;
  } ent_t;

  ent_t             m_q[$];
  logic [TAG_W-1:0] m_tag;
  logic             m_err, m_rv;
  logic [PTR_W-1:0] m_rptr;
  logic [XLEN-1:0]  m_rtop;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_clear();
    m_q.delete();
    m_tag  = '0;
    m_err  = 1'b0;
    m_rv   = 1'b0;
    m_rptr = '0;
    m_rtop = '0;
  endtask

  // Entered one time unit after a rising edge; leaves at the same phase.
  task automatic step(input logic fl, input logic av, input logic [PTR_W-1:0] p,
                      input logic [XLEN-1:0] t, input logic rv,
                      input logic [TAG_W-1:0] rt, input logic rm);
    logic exp_rdy, acc, hit;
    flush = fl; alloc_valid = av; alloc_ptr = p; alloc_top = t;
    resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm;
    #1;
    exp_rdy = (m_q.size() < DEPTH) && !fl && !(rv && rm);
    chk("alloc_ready", alloc_ready, exp_rdy);
    chk("alloc_tag", alloc_tag, m_tag);
    acc  = av && exp_rdy;
    hit  = (m_q.size() > 0) && (m_q[0].tag == rt);
    m_rv = 1'b0;
    if (fl) begin
      m_q.delete();
    end else if (rv && rm) begin
      if (hit) begin
        m_rv   = 1'b1;
        m_rptr = m_q[0].ptr;
        m_rtop = TOP_EN ? m_q[0].top : '0;
      end else m_err = 1'b1;
      m_q.delete();
    end else begin
      if (rv && !hit) m_err = 1'b1;
      if (acc) begin
        m_q.push_back('{ptr: p, top: t, tag: m_tag});
        m_tag = m_tag + 1'b1;
      end
      if (rv && hit) void'(m_q.pop_front());
    end
    @(posedge clk);
    #1;
    chk("count", count, m_q.size());
    chk("restore_valid", restore_valid, m_rv);
    chk("restore_ptr", restore_ptr, m_rptr);
    chk("restore_top", restore_top, m_rtop);
    chk("tag_err", tag_err, m_err);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    flush = 0; alloc_valid = 0; alloc_ptr = '0; alloc_top = '0;
    resolve_valid = 0; resolve_tag = '0; resolve_mispredict = 0;
    reset = 1'b1;
    #1;
    model_clear();
    chk("rst_ready", alloc_ready, 1'b1);
    chk("rst_tag", alloc_tag, 0);
    chk("rst_count", count, 0);
    chk("rst_rv", restore_valid, 1'b0);
    chk("rst_rptr", restore_ptr, 0);
    chk("rst_rtop", restore_top, 0);
    chk("rst_err", tag_err, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  logic             r_fl, r_av, r_rv, r_rm;
  logic [TAG_W-1:0] r_rt;

  initial begin
    reset = 1'b0;
    #2;
    // Fill to capacity; the fifth attempt must be refused.
    do_reset();
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b1, PTR_W'(i), 32'(i * 16), 1'b0, '0, 1'b0);
    chk("fill_count", count, 4);
    chk("fill_ready", alloc_ready, 1'b0);

    // Correct resolve then mispredict with restore payload.
    do_reset();
    step(1'b0, 1'b1, 3'd1, 32'h100, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 3'd2, 32'h200, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 1'b0);
    chk("pop_count", count, 1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd1, 1'b1);
    chk("mp_rv", restore_valid, 1'b1);
    chk("mp_ptr", restore_ptr, 2);
    chk("mp_top", restore_top, TOP_EN ? 32'h200 : 32'h0);
    chk("mp_count", count, 0);
    idle();
    chk("mp_pulse_end", restore_valid, 1'b0);
    chk("mp_ptr_hold", restore_ptr, 2);

    // Tag wrap over ten accept/resolve pairs.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("wrap_tag", alloc_tag, i % 8);
      step(1'b0, 1'b1, PTR_W'(i), 32'(i), 1'b0, '0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, TAG_W'(i % 8), 1'b0);
    end
    chk("wrap_err", tag_err, 1'b0);

    // Tag mismatch is sticky.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PTR_W'(i), '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd1, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd5, 1'b0);
    chk("bad_tag_err", tag_err, 1'b1);
    chk("bad_tag_count", count, 1);
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, PTR_W'(i), '0, 1'b0, '0, 1'b0);
    chk("bad_tag_sticky", tag_err, 1'b1);

    // Flush beats a coincident mispredict.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, PTR_W'(i + 1), '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 3'd7, '0, 1'b1, 3'd0, 1'b1);
    chk("flush_count", count, 0);
    chk("flush_rv", restore_valid, 1'b0);

    // Mispredict drops a coincident alloc; reset kills a live restore pulse.
    do_reset();
    step(1'b0, 1'b1, 3'd3, '0, 1'b1, 3'd0, 1'b1);
    chk("drop_count", count, 0);
    do_reset();
    step(1'b0, 1'b1, 3'd6, 32'hABC, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 3'd0, 1'b1);
    chk("pre_rst_rv", restore_valid, 1'b1);
    reset = 1'b1;
    #1;
    chk("async_rst_rv", restore_valid, 1'b0);
    reset = 1'b0;

    // Randomized traffic against the queue model.
    @(posedge clk);
    #1;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        r_fl = ($urandom_range(0, 24) == 0);
        r_av = ($urandom_range(0, 3) != 0);
        r_rv = ($urandom_range(0, 2) == 0);
        r_rm = ($urandom_range(0, 5) == 0);
        if (m_q.size() > 0 && $urandom_range(0, 19) != 0) r_rt = m_q[0].tag;
        else r_rt = TAG_W'($urandom);
        step(r_fl, r_av, PTR_W'($urandom), $urandom, r_rv, r_rt, r_rm);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
